// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv - IJTAG TDR segment and glitch-safe hand-off sequencer for a tessent_data_mux
module firebird7_in_gate1_tessent_data_mux_ctrl #(
  parameter int WIDTH         = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] functional_data_in,
  output logic [WIDTH-1:0] mux_data_out,
  output logic             mux_select_out,
  output logic             busy
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_FUNC,
    ST_SET_ON,
    ST_OVR,
    ST_SET_OFF
  } state_t;

  logic [WIDTH:0]   r_sr;
  logic [WIDTH-1:0] r_data;
  logic             r_select;
  logic             r_target;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  state_t           r_state;

  logic w_cap;
  logic w_shift;
  logic w_upd;
  logic w_target_nxt;

  // Segment ops are qualified by ijtag_sel and prioritised ce > se > ue.
  assign w_cap   = ijtag_sel & ijtag_ce;
  assign w_shift = ijtag_sel & ~ijtag_ce & ijtag_se;
  assign w_upd   = ijtag_sel & ~ijtag_ce & ~ijtag_se & ijtag_ue;

  // A late update landing on the settle-end edge still decides the outcome.
  assign w_target_nxt = w_upd ? r_sr[WIDTH] : r_target;

  always_ff @(posedge ijtag_tck) begin
    if (!ijtag_reset) begin
      r_sr     <= '0;
      r_data   <= '0;
      r_select <= 1'b0;
      r_target <= 1'b0;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_state  <= ST_FUNC;
    end else begin
      if (w_cap) begin
        r_sr <= {r_select, functional_data_in};
      end else if (w_shift) begin
        r_sr <= {ijtag_si, r_sr[WIDTH:1]};
      end

      if (w_upd) begin
        r_data   <= r_sr[WIDTH-1:0];
        r_target <= r_sr[WIDTH];
      end

      case (r_state)
        ST_FUNC: begin
          if (w_upd && r_sr[WIDTH]) begin
            r_state <= ST_SET_ON;
            r_cnt   <= CNT_LOAD;
            r_busy  <= 1'b1;
          end
        end
        ST_SET_ON: begin
          if (r_cnt == '0) begin
            r_busy <= 1'b0;
            if (w_target_nxt) begin
              r_state  <= ST_OVR;
              r_select <= 1'b1;
            end else begin
              r_state <= ST_FUNC;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_OVR: begin
          if (w_upd && !r_sr[WIDTH]) begin
            r_state  <= ST_SET_OFF;
            r_select <= 1'b0;
            r_cnt    <= CNT_LOAD;
            r_busy   <= 1'b1;
          end
        end
        ST_SET_OFF: begin
          if (r_cnt == '0) begin
            if (w_target_nxt) begin
              r_state <= ST_SET_ON;
              r_cnt   <= CNT_LOAD;
            end else begin
              r_state <= ST_FUNC;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state  <= ST_FUNC;
          r_select <= 1'b0;
          r_busy   <= 1'b0;
          r_cnt    <= '0;
        end
      endcase
    end
  end

  assign ijtag_so       = r_sr[0];
  assign mux_data_out   = r_data;
  assign mux_select_out = r_select;
  assign busy           = r_busy;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv
// tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv - directed self-checking bench for the data mux TDR controller
module tb_firebird7_in_gate1_tessent_data_mux_ctrl;

  logic       tck = 1'b0;
  logic       rstn;
  logic       sel;
  logic       ce;
  logic       se;
  logic       ue;
  logic       si;
  logic [2:0] fdi;

  logic       so;
  logic [2:0] data;
  logic       msel;
  logic       bsy;
  logic       so4;
  logic [2:0] data4;
  logic       msel4;
  logic       bsy4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 tck = ~tck;

  firebird7_in_gate1_tessent_data_mux_ctrl #(.WIDTH(3), .SETTLE_CYCLES(2)) u_dut (
    .ijtag_tck          (tck),
    .ijtag_reset        (rstn),
    .ijtag_sel          (sel),
    .ijtag_ce           (ce),
    .ijtag_se           (se),
    .ijtag_ue           (ue),
    .ijtag_si           (si),
    .ijtag_so           (so),
    .functional_data_in (fdi),
    .mux_data_out       (data),
    .mux_select_out     (msel),
    .busy               (bsy)
  );

  // Longer settle so a second update fits inside the window.
  firebird7_in_gate1_tessent_data_mux_ctrl #(.WIDTH(3), .SETTLE_CYCLES(4)) u_dut4 (
    .ijtag_tck          (tck),
    .ijtag_reset        (rstn),
    .ijtag_sel          (sel),
    .ijtag_ce           (ce),
    .ijtag_se           (se),
    .ijtag_ue           (ue),
    .ijtag_si           (si),
    .ijtag_so           (so4),
    .functional_data_in (fdi),
    .mux_data_out       (data4),
    .mux_select_out     (msel4),
    .busy               (bsy4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic shift_in(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      si = v[i];
      se = 1'b1;
      tick();
    end
    se = 1'b0;
    si = 1'b0;
  endtask

  task automatic pulse_ue();
    ue = 1'b1;
    tick();
    ue = 1'b0;
  endtask

  initial begin
    logic [4:0] exp_so;
    rstn = 1'b0;
    sel  = 1'b1;
    ce   = 1'b0;
    se   = 1'b0;
    ue   = 1'b0;
    si   = 1'b1;
    fdi  = 3'b111;

    for (int i = 0; i < 3; i++) begin
      ce = i[0];
      se = ~i[0];
      ue = 1'b1;
      tick();
    end
    chk("rst_data", {29'd0, data}, 32'd0);
    chk("rst_sel", {31'd0, msel}, 32'd0);
    chk("rst_busy", {31'd0, bsy}, 32'd0);
    chk("rst_so", {31'd0, so}, 32'd0);

    rstn = 1'b1;
    ce   = 1'b0;
    se   = 1'b0;
    ue   = 1'b0;
    si   = 1'b0;
    tick();

    fdi = 3'b101;
    ce  = 1'b1;
    tick();
    ce  = 1'b0;
    exp_so = 5'b10101;
    chk("cap_so", {31'd0, so}, {31'd0, exp_so[4]});
    si = 1'b1;
    se = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("shift_so%0d", i), {31'd0, so}, {31'd0, exp_so[3-i]});
    end
    si = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("drain_so%0d", i), {31'd0, so}, 32'd1);
    end
    se = 1'b0;

    shift_in(4'b1110);
    pulse_ue();
    chk("on_data", {29'd0, data}, 32'b110);
    chk("on_busy1", {31'd0, bsy}, 32'd1);
    chk("on_sel1", {31'd0, msel}, 32'd0);
    tick();
    chk("on_busy2", {31'd0, bsy}, 32'd1);
    chk("on_sel2", {31'd0, msel}, 32'd0);
    tick();
    chk("on_sel3", {31'd0, msel}, 32'd1);
    chk("on_busy3", {31'd0, bsy}, 32'd0);

    shift_in(4'b0011);
    chk("ovr_hold_sel", {31'd0, msel}, 32'd1);
    pulse_ue();
    chk("off_sel1", {31'd0, msel}, 32'd0);
    chk("off_data", {29'd0, data}, 32'b011);
    chk("off_busy1", {31'd0, bsy}, 32'd1);
    tick();
    chk("off_busy2", {31'd0, bsy}, 32'd1);
    tick();
    chk("off_busy3", {31'd0, bsy}, 32'd0);
    chk("off_sel3", {31'd0, msel}, 32'd0);

    shift_in(4'b1101);
    chk("pre_so", {31'd0, so}, 32'd1);
    sel = 1'b0;
    fdi = 3'b000;
    ce  = 1'b1;
    tick();
    ce  = 1'b0;
    chk("nsel_cap_so", {31'd0, so}, 32'd1);
    se  = 1'b1;
    tick();
    se  = 1'b0;
    chk("nsel_shift_so", {31'd0, so}, 32'd1);
    pulse_ue();
    chk("nsel_upd_data", {29'd0, data}, 32'b011);
    chk("nsel_upd_busy", {31'd0, bsy}, 32'd0);
    chk("nsel_upd_sel", {31'd0, msel}, 32'd0);
    sel = 1'b1;

    shift_in(4'b1010);
    pulse_ue();
    chk("rson_busy", {31'd0, bsy}, 32'd1);
    chk("rson_data", {29'd0, data}, 32'b010);
    rstn = 1'b0;
    tick();
    chk("rson_rst_busy", {31'd0, bsy}, 32'd0);
    chk("rson_rst_sel", {31'd0, msel}, 32'd0);
    chk("rson_rst_data", {29'd0, data}, 32'd0);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rson_post_sel%0d", i), {31'd0, msel}, 32'd0);
      chk($sformatf("rson_post_busy%0d", i), {31'd0, bsy}, 32'd0);
    end

    shift_in(4'b1001);
    pulse_ue();
    chk("rt_busy0", {31'd0, bsy4}, 32'd1);
    chk("rt_data0", {29'd0, data4}, 32'b001);
    fdi = 3'b010;
    ce  = 1'b1;
    tick();
    ce  = 1'b0;
    chk("rt_busy1", {31'd0, bsy4}, 32'd1);
    pulse_ue();
    chk("rt_data2", {29'd0, data4}, 32'b010);
    chk("rt_busy2", {31'd0, bsy4}, 32'd1);
    chk("rt_sel2", {31'd0, msel4}, 32'd0);
    tick();
    chk("rt_busy3", {31'd0, bsy4}, 32'd1);
    chk("rt_sel3", {31'd0, msel4}, 32'd0);
    tick();
    chk("rt_busy4", {31'd0, bsy4}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rt_sel_after%0d", i), {31'd0, msel4}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/firebird7_in_gate1_tessent_data_mux_ctrl.md
# firebird7_in_gate1_tessent_data_mux_ctrl

- IJTAG test data register (TDR) segment and hand-off sequencer that drives one 3-bit `tessent_data_mux` instance (`ijtag_select`, `ijtag_data_in`).
- Shifts in a data override value plus a select request, captures the live functional value for observation, and applies the override glitch-safely: override data is driven and allowed to settle before select asserts, and select releases before data is considered free.
- Sits in the gate1 IJTAG network between the SIB-controlled scan path and the data mux.

## Interface

Parameters:
- `WIDTH`, 3: mux data width.
- `SETTLE_CYCLES`, 2: settle cycles between data change and select change. Legal values are ≥ 1.

Ports:
- `ijtag_tck`, in, 1: the block's only clock.
- `ijtag_reset`, in, 1: reset, synchronous, active-low.
- `ijtag_sel`, in, 1: segment selected. Capture, shift and update are ignored when this is low.
- `ijtag_ce`, in, 1: capture enable.
- `ijtag_se`, in, 1: shift enable.
- `ijtag_ue`, in, 1: update enable.
- `ijtag_si`, in, 1: scan in.
- `ijtag_so`, out, 1: scan out, equal to `sr[0]`, combinational from the register.
- `functional_data_in`, in, WIDTH: live functional value, observed on capture.
- `mux_data_out`, out, WIDTH: drives the mux `ijtag_data_in`.
- `mux_select_out`, out, 1: drives the mux `ijtag_select`.
- `busy`, out, 1: high while a settle is in progress.

## Operation

- Shift register `sr` is WIDTH+1 bits. Bit `[WIDTH]` is the select request; bits `[WIDTH-1:0]` are data.
- Segment ops apply only when `ijtag_sel`=1. Priority is ce > se > ue; the three are not expected to be asserted together.
  - Capture: `sr <= {mux_select_out, functional_data_in}`.
  - Shift: `sr <= {ijtag_si, sr[WIDTH:1]}`. Bit 0 leaves first, so `ijtag_si` supplies the MSB last.
  - Update: `mux_data_out <= sr[WIDTH-1:0]` and `target <= sr[WIDTH]`. The sequencer reacts on the following cycle.
- `sr` holds when no operation is enabled.
- Sequencer states and transitions:
  - FUNC: select=0, busy=0. An update with target=1 loads `cnt = SETTLE_CYCLES-1` and goes to SET_ON. An update with target=0 only changes data.
  - SET_ON: select=0, busy=1. Decrements `cnt`. When `cnt`=0: if target=1 go to OVR and assert select; else go to FUNC.
  - OVR: select=1, busy=0. An update with target=0 deasserts select on the next cycle, loads `cnt`, and goes to SET_OFF. An update with target=1 changes data only and stays in OVR.
  - SET_OFF: select=0, busy=1. Decrements `cnt`. When `cnt`=0: if target=1, reload `cnt` and go to SET_ON; else go to FUNC.
- Updates during SET_ON or SET_OFF overwrite data and target. The counter is not restarted; the target is evaluated at settle end.
- `cnt` width is `$clog2(SETTLE_CYCLES+1)`. It never underflows and holds at 0 outside the settle states.
- Reset values: `sr`=0, `mux_data_out`=0, `mux_select_out`=0, `target`=0, state=FUNC, `busy`=0, `cnt`=0. Reset has priority over all segment ops.
- Reset mid-settle drops select and returns to FUNC immediately. No residual settle is performed.

## Timing

- Update sampled at edge N:
  - `mux_data_out` changes at N+1.
  - From FUNC with target=1: `busy` rises at N+1, `mux_select_out` rises at N+1+SETTLE_CYCLES, and `busy` falls in the same cycle.
  - From OVR with target=0: `mux_select_out` falls at N+1, `busy` is high for SETTLE_CYCLES cycles starting at N+1, and the state reaches FUNC at N+1+SETTLE_CYCLES.
- Capture at edge N reflects `mux_select_out` and `functional_data_in` as sampled at edge N.
- `ijtag_so` changes only after clock edges; there are no combinational paths from inputs.
- `mux_select_out` is glitch-free: it comes directly from a flop and changes at most once per settle sequence.

## Test plan

- **Reset:** hold `ijtag_reset`=0 for 3 cycles with ce/se/ue toggling -> all outputs 0, `ijtag_so`=0.
- **Shift/observe:** `functional_data_in`=3'b101; capture, then 4 shifts with si=1 -> `ijtag_so` sequence 1,0,1,0, then `sr`=4'b1111.
- **Override on** (SETTLE_CYCLES=2): shift in 4'b1110 (select=1, data=3'b110), then update at cycle N -> data=110 at N+1, busy high at N+1..N+2, select=1 at N+3.
- **Override off:** from OVR, update with 4'b0011 -> select=0 one cycle after the update, data=011, busy high for 2 cycles, then FUNC.
- **Retarget mid-settle:** update on then, one cycle later, update off -> select never asserts; state returns to FUNC after the original settle.
- **`ijtag_sel`=0:** ce/se/ue pulses while deselected -> `sr`, outputs and state unchanged. Also assert reset during SET_ON -> immediate return to FUNC with select=0.
